// File: rtl/spm_cisr_pkg.sv
// Shared types for the CISR encoder/decoder pair: encoder FSM states and row-id width.
package spm_cisr_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } enc_state_t;

  localparam int DIM_W = 16;

endpackage

// File: rtl/cisr_chan_arb.sv
// Lowest-set-bit priority encoder: one-hot grant, binary index and any-request flag.
module cisr_chan_arb #(
  parameter int NUM_CH = 16,
  parameter int CHAN_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] grant,
  output logic [CHAN_W-1:0] idx,
  output logic              any
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    grant = '0;
    idx   = '0;
    any   = |req;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = CHAN_W'(i);
      end
    end
  end

endmodule

// File: rtl/cisr_encoder.sv
// CISR encoder: binds CSR rows to the lowest free channel and emits per-slot channel activity.
module cisr_encoder
  import spm_cisr_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spmv_init,
  input  logic [DATA_W-1:0] row_len_in,
  input  logic              row_valid,
  input  logic              row_last,
  output logic              row_ready,
  output logic [NUM_CH-1:0] row_len_push,
  output logic [DATA_W-1:0] row_len_out,
  output logic [DIM_W-1:0]  row_id_out,
  output logic              slot_valid,
  input  logic              slot_ready,
  output logic [NUM_CH-1:0] slot_active,
  output logic              done
);

  localparam int CHAN_W = $clog2(NUM_CH);

  enc_state_t        state_q, state_d;
  logic [DATA_W-1:0] count_q [NUM_CH];
  logic [NUM_CH-1:0] busy, retired, need, need_after, grant;
  logic [CHAN_W-1:0] grant_idx;
  logic              any_need, accept, consume, len_nz;
  logic [DIM_W-1:0]  row_id_q;

  // A channel wants a new row when it has nothing left to stream and input is not exhausted.
  assign need = ~busy & ~retired;

  cisr_chan_arb #(.NUM_CH(NUM_CH), .CHAN_W(CHAN_W)) u_arb (
    .req   (need),
    .grant (grant),
    .idx   (grant_idx),
    .any   (any_need)
  );

  assign accept       = row_valid & row_ready;
  assign consume      = slot_valid & slot_ready;
  assign len_nz       = |row_len_in;
  assign need_after   = need & ~(grant & {NUM_CH{accept & len_nz}});
  assign row_len_push = grant & {NUM_CH{accept}};
  assign row_len_out  = accept ? row_len_in : '0;
  assign row_id_out   = row_id_q;
  assign slot_active  = slot_valid ? busy : '0;

  always_comb begin
    state_d    = state_q;
    row_ready  = 1'b0;
    slot_valid = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      FILL: begin
        row_ready = any_need & ~spmv_init;
        if (accept && row_last)  state_d = DRAIN;
        else if (!(|need_after)) state_d = RUN;
      end
      RUN: begin
        row_ready  = any_need & ~spmv_init;
        slot_valid = ~any_need & ~spmv_init;
        if (accept && row_last) state_d = DRAIN;
      end
      DRAIN: begin
        slot_valid = (|busy) & ~spmv_init;
        if (!(|busy)) state_d = DONE;
      end
      DONE: done = 1'b1;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registered state always uses non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q  <= FILL;
      row_id_q <= '0;
    end else if (spmv_init) begin
      state_q  <= FILL;
      row_id_q <= '0;
    end else begin
      state_q  <= state_d;
      row_id_q <= row_id_q + DIM_W'(accept);
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
    logic retired_q;

    assign busy[ch]    = count_q[ch] != '0;
    assign retired[ch] = retired_q;

    // NOTE: the per-channel counts are discrete flops rather than a RAM, so they take the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        count_q[ch] <= '0;
        retired_q   <= 1'b0;
      end else if (spmv_init) begin
        count_q[ch] <= '0;
        retired_q   <= 1'b0;
      end else begin
        if (accept && grant_idx == CHAN_W'(ch)) count_q[ch] <= row_len_in;
        else if (consume && busy[ch])           count_q[ch] <= count_q[ch] - DATA_W'(1);
        // Once the final row is taken, every channel left empty becomes a permanent bubble.
        if (accept && row_last && need_after[ch]) retired_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cisr_encoder.sv
// Self-checking bench for cisr_encoder: directed scenarios plus random streams vs a CISR schedule model.
module tb_cisr_encoder;
  import spm_cisr_pkg::*;

  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 8;
  localparam int CYC_LIMIT = 4000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              spmv_init = 1'b0;
  logic [DATA_W-1:0] row_len_in = '0;
  logic              row_valid = 1'b0;
  logic              row_last = 1'b0;
  logic              row_ready;
  logic [NUM_CH-1:0] row_len_push;
  logic [DATA_W-1:0] row_len_out;
  logic [DIM_W-1:0]  row_id_out;
  logic              slot_valid;
  logic              slot_ready = 1'b0;
  logic [NUM_CH-1:0] slot_active;
  logic              done;

  int n_checks = 0;
  int n_pass   = 0;

  int                rows_q[$];
  int                got_ch[$];
  int                got_cyc[$];
  logic [NUM_CH-1:0] got_slot[$];
  int                exp_ch[$];
  logic [NUM_CH-1:0] exp_slot[$];
  bit                reached_done;

  cisr_encoder #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spmv_init    (spmv_init),
    .row_len_in   (row_len_in),
    .row_valid    (row_valid),
    .row_last     (row_last),
    .row_ready    (row_ready),
    .row_len_push (row_len_push),
    .row_len_out  (row_len_out),
    .row_id_out   (row_id_out),
    .slot_valid   (slot_valid),
    .slot_ready   (slot_ready),
    .slot_active  (slot_active),
    .done         (done)
  );

  always #5 clk = ~clk;

  function automatic int onehot_idx(input logic [NUM_CH-1:0] v);
    int idx = -1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (v[i]) begin
        if (idx >= 0) return -1;
        idx = i;
      end
    end
    return idx;
  endfunction

  // Schedule model: bind every pending row before each slot, then all busy channels advance together.
  task automatic golden();
    int rem[NUM_CH];
    bit ret[NUM_CH];
    int r, n, ch;
    logic [NUM_CH-1:0] act;
    exp_ch.delete();
    exp_slot.delete();
    foreach (rem[i]) begin rem[i] = 0; ret[i] = 1'b0; end
    n = rows_q.size();
    r = 0;
    forever begin
      while (r < n) begin
        ch = -1;
        for (int i = NUM_CH - 1; i >= 0; i--) if (rem[i] == 0 && !ret[i]) ch = i;
        if (ch < 0) break;
        exp_ch.push_back(ch);
        rem[ch] = rows_q[r];
        if (r == n - 1) foreach (rem[i]) if (rem[i] == 0) ret[i] = 1'b1;
        r++;
      end
      act = '0;
      foreach (rem[i]) if (rem[i] != 0) act[i] = 1'b1;
      if (act == '0) break;
      exp_slot.push_back(act);
      foreach (rem[i]) if (rem[i] > 0) rem[i]--;
    end
  endtask

  task automatic restart();
    @(negedge clk);
    spmv_init = 1'b1;
    row_valid = 1'b0;
    @(negedge clk);
    spmv_init = 1'b0;
  endtask

  // Streams rows_q into the DUT; stop_cyc>0 aborts early without end-of-run comparisons.
  task automatic run_rows(input int p_valid, input int p_ready, input int gap_row, input int stop_cyc);
    int ri, cyc, gap_cnt, n;
    bit prev_stall, want;
    logic [NUM_CH-1:0] prev_act;
    got_ch.delete();
    got_cyc.delete();
    got_slot.delete();
    reached_done = 1'b0;
    restart();
    n = rows_q.size();
    ri = 0; cyc = 0; gap_cnt = 0; prev_stall = 1'b0; prev_act = '0;
    while (cyc < CYC_LIMIT) begin
      if (cyc > 0) @(negedge clk);
      if (stop_cyc > 0 && cyc == stop_cyc) break;
      want       = (ri < n) && !(ri == gap_row && gap_cnt < 5) && (int'($urandom_range(99)) < p_valid);
      row_valid  = want;
      row_len_in = want ? DATA_W'(rows_q[ri]) : DATA_W'($urandom);
      row_last   = want && (ri == n - 1);
      slot_ready = int'($urandom_range(99)) < p_ready;
      #1;
      if (done) begin
        reached_done = 1'b1;
        break;
      end
      if (ri == gap_row && gap_cnt < 5 && row_ready) begin
        gap_cnt++;
        n_checks++;
        if (slot_valid !== 1'b0) $display("FAIL gap_stall cyc=%0d slot_valid=%b required 0", cyc, slot_valid);
        else n_pass++;
      end
      if (prev_stall) begin
        n_checks++;
        if (slot_valid !== 1'b1 || slot_active !== prev_act)
          $display("FAIL slot_hold cyc=%0d valid=%b active=%b required valid=1 active=%b",
                   cyc, slot_valid, slot_active, prev_act);
        else n_pass++;
      end
      n_checks++;
      if (row_valid && row_ready) begin
        if (onehot_idx(row_len_push) < 0 || row_len_out !== row_len_in || row_id_out !== DIM_W'(ri))
          $display("FAIL push_fields row=%0d push=%b len=%0d id=%0d required onehot len=%0d id=%0d",
                   ri, row_len_push, row_len_out, row_id_out, row_len_in, ri);
        else n_pass++;
        got_ch.push_back(onehot_idx(row_len_push));
        got_cyc.push_back(cyc);
        ri++;
      end else begin
        if (row_len_push !== '0) $display("FAIL idle_push cyc=%0d push=%b required 0", cyc, row_len_push);
        else n_pass++;
      end
      if (slot_valid && slot_ready) got_slot.push_back(slot_active);
      prev_stall = slot_valid && !slot_ready;
      prev_act   = slot_active;
      cyc++;
    end
    row_valid = 1'b0; row_last = 1'b0; slot_ready = 1'b0;
    if (stop_cyc > 0) return;
    n_checks++;
    if (!reached_done) $display("FAIL done_timeout done=0 required 1 within %0d cycles", CYC_LIMIT);
    else n_pass++;
    n_checks++;
    if (slot_valid !== 1'b0 || row_ready !== 1'b0)
      $display("FAIL done_quiet slot_valid=%b row_ready=%b required 0 0", slot_valid, row_ready);
    else n_pass++;
    golden();
    n_checks++;
    if (got_ch.size() != exp_ch.size() || got_slot.size() != exp_slot.size())
      $display("FAIL counts pushes=%0d slots=%0d required pushes=%0d slots=%0d",
               got_ch.size(), got_slot.size(), exp_ch.size(), exp_slot.size());
    else n_pass++;
    foreach (exp_ch[i]) begin
      n_checks++;
      if (i >= got_ch.size() || got_ch[i] != exp_ch[i])
        $display("FAIL push_chan row=%0d got=%0d required %0d", i, (i < got_ch.size()) ? got_ch[i] : -1, exp_ch[i]);
      else n_pass++;
    end
    foreach (exp_slot[i]) begin
      n_checks++;
      if (i >= got_slot.size() || got_slot[i] !== exp_slot[i])
        $display("FAIL slot_seq slot=%0d got=%b required %b", i, (i < got_slot.size()) ? got_slot[i] : '0, exp_slot[i]);
      else n_pass++;
    end
  endtask

  task automatic check_idle(input string tag);
    n_checks++;
    if (slot_valid !== 1'b0 || slot_active !== '0 || done !== 1'b0 || row_len_push !== '0 || row_id_out !== '0)
      $display("FAIL %s valid=%b active=%b done=%b push=%b id=%0d required all 0",
               tag, slot_valid, slot_active, done, row_len_push, row_id_out);
    else n_pass++;
  endtask

  task automatic test_reset();
    #2;
    check_idle("reset_outputs");
    #10 rst_n = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (row_ready !== 1'b1) $display("FAIL reset_fill row_ready=%b required 1", row_ready);
    else n_pass++;
  endtask

  task automatic test_fill_order();
    rows_q = '{2, 1, 3, 1, 2};
    run_rows(100, 100, -1, 0);
    for (int k = 0; k < NUM_CH; k++) begin
      n_checks++;
      if (k >= got_ch.size() || got_ch[k] != k || got_cyc[k] != k)
        $display("FAIL fill_order push=%0d chan=%0d cyc=%0d required chan=%0d cyc=%0d",
                 k, (k < got_ch.size()) ? got_ch[k] : -1, (k < got_cyc.size()) ? got_cyc[k] : -1, k, k);
      else n_pass++;
    end
  endtask

  task automatic test_zero_rows();
    rows_q = '{0, 0, 3, 1, 1, 1};
    run_rows(100, 100, -1, 0);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (k >= got_ch.size() || got_ch[k] != 0 || got_cyc[k] != k)
        $display("FAIL zero_rows push=%0d chan=%0d cyc=%0d required chan=0 cyc=%0d",
                 k, (k < got_ch.size()) ? got_ch[k] : -1, (k < got_cyc.size()) ? got_cyc[k] : -1, k);
      else n_pass++;
    end
  endtask

  task automatic test_few_rows();
    logic [NUM_CH-1:0] want_seq[4] = '{4'b0011, 4'b0011, 4'b0001, 4'b0001};
    rows_q = '{4, 2};
    run_rows(100, 100, -1, 0);
    foreach (want_seq[i]) begin
      n_checks++;
      if (i >= got_slot.size() || got_slot[i] !== want_seq[i])
        $display("FAIL few_rows slot=%0d got=%b required %b", i, (i < got_slot.size()) ? got_slot[i] : '0, want_seq[i]);
      else n_pass++;
    end
  endtask

  task automatic test_row_gap();
    rows_q = '{1, 1, 1, 1, 2, 3, 1};
    run_rows(100, 100, 4, 0);
  endtask

  task automatic test_random_streams();
    for (int t = 0; t < 4; t++) begin
      rows_q.delete();
      repeat ($urandom_range(20, 5)) rows_q.push_back(int'($urandom_range(6)));
      run_rows(70, 60, -1, 0);
    end
  endtask

  task automatic test_max_len();
    rows_q = '{255, 1};
    run_rows(100, 100, -1, 0);
  endtask

  task automatic test_back_to_back();
    rows_q = '{3, 2, 4, 1, 2, 3, 1, 2};
    run_rows(100, 100, -1, 6);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle("async_reset_mid_run");
    @(negedge clk);
    rst_n = 1'b1;
    run_rows(100, 80, -1, 0);
    rows_q = '{9, 1};
    run_rows(100, 100, -1, 5);
    restart();
    #1;
    check_idle("init_mid_drain");
    n_checks++;
    if (row_ready !== 1'b1) $display("FAIL init_fill row_ready=%b required 1", row_ready);
    else n_pass++;
    rows_q = '{1, 2, 1};
    run_rows(90, 70, -1, 0);
  endtask

  initial begin
    test_reset();
    test_fill_order();
    test_zero_rows();
    test_few_rows();
    test_row_gap();
    test_random_streams();
    test_max_len();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
